// File: rtl/regfile_pkg.sv
// -----------------------------------------------------------------------------
// regfile_pkg
//
// Shared declarations for the parametrised register file.
//   state_t        : initialisation-sequencer state (INIT walk, RUN).
//   INIT_ZERO      : INIT_MODE value, every register starts at zero.
//   INIT_INDEX     : INIT_MODE value, register i starts at i (zero-extended).
//   idx_width()    : number of bits needed to index DEPTH storage entries.
// -----------------------------------------------------------------------------
package regfile_pkg;

  typedef enum logic {
    INIT = 1'b0,
    RUN  = 1'b1
  } state_t;

  localparam int INIT_ZERO  = 0;
  localparam int INIT_INDEX = 1;

  // Width of a physical storage index. A single-entry file still gets one
  // bit so that every slice stays legal.
  function automatic int idx_width(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage : regfile_pkg

// File: rtl/regfile_init_seq.sv
// -----------------------------------------------------------------------------
// regfile_init_seq
//
// Sequencer for the register-file initialisation walk. After reset it writes
// one entry per clock, from index 0 up to DEPTH-1, and then moves to RUN and
// raises ready. It never wraps. Another reset restarts the walk at index 0.
//
// Parameters
//   DATA_W    : register width.
//   ADDR_W    : architectural register address width.
//   DEPTH     : number of implemented registers (1..2**ADDR_W).
//   INIT_MODE : INIT_ZERO or INIT_INDEX, the value written by the walk.
//
// Ports
//   clock_in   in   clock, rising-edge active.
//   reset      in   synchronous active-high reset.
//   init_we    out  the array write port belongs to the walk on this edge.
//   init_addr  out  storage index being initialised.
//   init_data  out  value written at init_addr.
//   ready      out  walk complete; the datapath may use the file.
// -----------------------------------------------------------------------------
module regfile_init_seq
  import regfile_pkg::*;
#(
  parameter int DATA_W    = 32,
  parameter int ADDR_W    = 5,
  parameter int DEPTH     = 16,
  parameter int INIT_MODE = INIT_INDEX
) (
  input  logic                               clock_in,
  input  logic                               reset,
  output logic                               init_we,
  output logic [idx_width(DEPTH)-1:0]        init_addr,
  output logic [DATA_W-1:0]                  init_data,
  output logic                               ready
);

  localparam int                IDX_W    = idx_width(DEPTH);
  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(DEPTH - 1);

  state_t            state;
  state_t            state_n;
  logic [ADDR_W-1:0] init_idx;
  logic [ADDR_W-1:0] init_idx_n;
  logic              ready_n;

  // State register. Reset only rewinds the walk; it never writes the array.
  always_ff @(posedge clock_in) begin
    if (reset) begin
      state    <= INIT;
      init_idx <= '0;
      ready    <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments let every register sample pre-edge
      // values, so the order of these statements does not matter.
      state    <= state_n;
      init_idx <= init_idx_n;
      ready    <= ready_n;
    end
  end

  // Next-state logic and the walk's array write request.
  always_comb begin
    // NOTE: every output of this block gets a default first; a path that left
    // one unassigned would infer a latch.
    state_n    = state;
    init_idx_n = init_idx;
    ready_n    = ready;
    init_we    = 1'b0;

    unique case (state)
      INIT: begin
        // The reset edge itself must not write the array.
        init_we = !reset;
        if (init_idx == LAST_IDX) begin
          // Last entry written on this edge; hold the index so it never wraps.
          state_n = RUN;
          ready_n = 1'b1;
        end else begin
          init_idx_n = init_idx + 1'b1;
        end
      end
      RUN: begin
        // Idle until the next reset.
      end
      default: begin
        state_n = INIT;
      end
    endcase
  end

  assign init_addr = init_idx[IDX_W-1:0];
  assign init_data = (INIT_MODE == INIT_INDEX) ? DATA_W'(init_idx) : '0;

endmodule : regfile_init_seq

// File: rtl/regfile_param.sv
// -----------------------------------------------------------------------------
// regfile_param
//
// Two-read / one-write general-purpose register file for the CPU datapaths.
// The storage is initialised by a walk that writes one entry per cycle after
// reset (see regfile_init_seq). Until the walk finishes, writes are ignored
// and both read ports return zero. Register 0 can be made hard-wired zero.
//
// Build option
//   REGFILE_BYPASS_EN : when defined, a legal same-cycle write is forwarded to
//                       any read port that addresses the written register.
//                       This covers the writeback/decode overlap. When it is
//                       undefined, a write becomes visible after its edge.
//
// Parameters
//   DATA_W    : register width.
//   ADDR_W    : register address width.
//   DEPTH     : implemented registers, 1..2**ADDR_W; higher addresses read 0
//               and drop writes.
//   INIT_MODE : INIT_ZERO (0) or INIT_INDEX (1, register i starts at i).
//   ZERO_REG  : 1 = register 0 reads 0 and ignores writes.
//
// Ports
//   clock_in   in   clock, rising-edge active.
//   reset      in   synchronous active-high reset.
//   readReg1   in   read port 1 address.
//   readReg2   in   read port 2 address.
//   writeReg   in   write address.
//   writeData  in   write data.
//   regWrite   in   write enable (honoured only when ready).
//   readData1  out  read port 1 data, combinational.
//   readData2  out  read port 2 data, combinational.
//   ready      out  initialisation complete.
// -----------------------------------------------------------------------------
module regfile_param
  import regfile_pkg::*;
#(
  parameter int DATA_W    = 32,
  parameter int ADDR_W    = 5,
  parameter int DEPTH     = 16,
  parameter int INIT_MODE = INIT_INDEX,
  parameter int ZERO_REG  = 1
) (
  input  logic              clock_in,
  input  logic              reset,
  input  logic [ADDR_W-1:0] readReg1,
  input  logic [ADDR_W-1:0] readReg2,
  input  logic [ADDR_W-1:0] writeReg,
  input  logic [DATA_W-1:0] writeData,
  input  logic              regWrite,
  output logic [DATA_W-1:0] readData1,
  output logic [DATA_W-1:0] readData2,
  output logic              ready
);

  localparam int IDX_W = idx_width(DEPTH);
  // One extra bit so that DEPTH == 2**ADDR_W is still representable.
  localparam logic [ADDR_W:0] DEPTH_EXT = (ADDR_W + 1)'(DEPTH);

  // ---------------------------------------------------------------------------
  // Initialisation sequencer
  // ---------------------------------------------------------------------------
  logic              init_we;
  logic [IDX_W-1:0]  init_addr;
  logic [DATA_W-1:0] init_data;

  regfile_init_seq #(
    .DATA_W    (DATA_W),
    .ADDR_W    (ADDR_W),
    .DEPTH     (DEPTH),
    .INIT_MODE (INIT_MODE)
  ) u_init_seq (
    .clock_in  (clock_in),
    .reset     (reset),
    .init_we   (init_we),
    .init_addr (init_addr),
    .init_data (init_data),
    .ready     (ready)
  );

  // ---------------------------------------------------------------------------
  // Address qualification
  // ---------------------------------------------------------------------------
  // True when addr names a real, writable and readable register: inside
  // DEPTH and not the hard-wired zero register.
  function automatic logic addr_ok(input logic [ADDR_W-1:0] addr);
    logic in_range;
    logic is_zero;
    in_range = ({1'b0, addr} < DEPTH_EXT);
    is_zero  = (ZERO_REG != 0) && (addr == '0);
    return in_range && !is_zero;
  endfunction

  logic wr_legal;
  logic run_we;

  assign wr_legal = regWrite && addr_ok(writeReg);
  // Datapath writes need RUN, and a reset edge must leave the array alone.
  assign run_we   = ready && wr_legal && !reset;

  // ---------------------------------------------------------------------------
  // Storage and write mux
  // ---------------------------------------------------------------------------
  logic [DATA_W-1:0] mem [DEPTH];

  // NOTE: the array has no reset branch on purpose. The initialisation walk
  // gives every entry a defined value before ready, so the storage can map
  // onto plain RAM/flop arrays without a reset network.
  always_ff @(posedge clock_in) begin
    if (init_we) begin
      mem[init_addr] <= init_data;
    end else if (run_we) begin
      mem[writeReg[IDX_W-1:0]] <= writeData;
    end
  end

  // ---------------------------------------------------------------------------
  // Read ports
  // ---------------------------------------------------------------------------
  always_comb begin
    readData1 = '0;
    readData2 = '0;
    // The walk is still running; contents are not yet valid.
    if (ready) begin
      if (addr_ok(readReg1)) readData1 = mem[readReg1[IDX_W-1:0]];
      if (addr_ok(readReg2)) readData2 = mem[readReg2[IDX_W-1:0]];
`ifdef REGFILE_BYPASS_EN
      // Forward a legal write in the same cycle. A dropped write, whether out
      // of range or to the zero register, is never forwarded.
      if (wr_legal && (readReg1 == writeReg)) readData1 = writeData;
      if (wr_legal && (readReg2 == writeReg)) readData2 = writeData;
`endif
    end
  end

endmodule : regfile_param

// File: tb/tb_regfile_param.sv
// -----------------------------------------------------------------------------
// tb_regfile_param
//
// Scoreboard bench for regfile_param. A driver applies one cycle of stimulus,
// pushes the reference model's expected outputs for that cycle and then
// advances the model across the clock edge. A monitor pops one entry every
// falling edge and compares. Two instances are used: the default build, and
// INIT_MODE=0 / DATA_W=16 / DEPTH=32 with no zero register.
// Honours REGFILE_BYPASS_EN in the same way as the design.
// -----------------------------------------------------------------------------
module tb_regfile_param;

  logic clock_in = 1'b0;
  always #5 clock_in = ~clock_in;

  // ---- instance A: default parameters -------------------------------------
  logic        reset;
  logic [4:0]  readReg1, readReg2, writeReg;
  logic [31:0] writeData;
  logic        regWrite;
  logic [31:0] readData1, readData2;
  logic        ready;

  regfile_param dut (
    .clock_in  (clock_in),
    .reset     (reset),
    .readReg1  (readReg1),
    .readReg2  (readReg2),
    .writeReg  (writeReg),
    .writeData (writeData),
    .regWrite  (regWrite),
    .readData1 (readData1),
    .readData2 (readData2),
    .ready     (ready)
  );

  // ---- instance B: zero init, 16-bit, full 32-entry depth ------------------
  logic        reset_b;
  logic [4:0]  read1_b, read2_b, wreg_b;
  logic [15:0] wdata_b;
  logic        we_b;
  logic [15:0] rdata1_b, rdata2_b;
  logic        ready_b;

  regfile_param #(
    .DATA_W    (16),
    .ADDR_W    (5),
    .DEPTH     (32),
    .INIT_MODE (0),
    .ZERO_REG  (0)
  ) dut_b (
    .clock_in  (clock_in),
    .reset     (reset_b),
    .readReg1  (read1_b),
    .readReg2  (read2_b),
    .writeReg  (wreg_b),
    .writeData (wdata_b),
    .regWrite  (we_b),
    .readData1 (rdata1_b),
    .readData2 (rdata2_b),
    .ready     (ready_b)
  );

  // ---- checking -------------------------------------------------------------
  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  typedef struct {
    bit          inst_b;
    logic [31:0] rd1;
    logic [31:0] rd2;
    logic        rdy;
    string       tag;
  } exp_t;

  exp_t sb_q[$];

  // Monitor: one expected entry per cycle, compared mid-cycle.
  initial begin
    exp_t e;
    forever begin
      @(negedge clock_in);
      if (sb_q.size() > 0) begin
        e = sb_q.pop_front();
        if (!e.inst_b) begin
          check({e.tag, "_rd1"},  readData1, e.rd1);
          check({e.tag, "_rd2"},  readData2, e.rd2);
          check({e.tag, "_rdy"},  32'(ready), 32'(e.rdy));
        end else begin
          check({e.tag, "_rd1"},  {16'h0, rdata1_b}, e.rd1);
          check({e.tag, "_rd2"},  {16'h0, rdata2_b}, e.rd2);
          check({e.tag, "_rdy"},  32'(ready_b), 32'(e.rdy));
        end
      end
    end
  end

  // ---- reference model, instance A ------------------------------------------
  // Registers 0..15 exist, 0 is hard-wired zero, and the initial value of
  // register i is i. The array covers the whole address space for simplicity.
  logic [31:0] m_mem [32];
  int          m_walked = 0;   // INIT edges completed since the last reset
  bit          m_ready  = 0;
  bit          m_known  = 0;   // outputs undefined until the first reset edge

  function automatic bit m_legal(input bit we, input int wa);
    return we && (wa < 16) && (wa != 0);
  endfunction

  function automatic logic [31:0] m_read(input int a, input bit we, input int wa,
                                         input logic [31:0] wd);
    if (!m_ready) return 32'h0;
`ifdef REGFILE_BYPASS_EN
    if (m_legal(we, wa) && (a == wa)) return wd;
`endif
    if (a >= 16 || a == 0) return 32'h0;
    return m_mem[a];
  endfunction

  task automatic m_edge(input bit rst, input bit we, input int wa, input logic [31:0] wd);
    if (rst) begin
      m_walked = 0;
      m_ready  = 0;
      m_known  = 1;
    end else if (!m_ready) begin
      m_mem[m_walked] = 32'(m_walked);
      m_walked++;
      if (m_walked == 16) m_ready = 1;
    end else if (m_legal(we, wa)) begin
      m_mem[wa] = wd;
    end
  endtask

  // One cycle on instance A: drive, predict, advance across the edge.
  task automatic step(input bit rst, input bit we, input int wa, input logic [31:0] wd,
                      input int r1, input int r2, input string tag);
    exp_t e;
    reset     = rst;
    regWrite  = we;
    writeReg  = 5'(wa);
    writeData = wd;
    readReg1  = 5'(r1);
    readReg2  = 5'(r2);
    if (m_known) begin
      e.inst_b = 0;
      e.rd1    = m_read(r1, we, wa, wd);
      e.rd2    = m_read(r2, we, wa, wd);
      e.rdy    = m_ready;
      e.tag    = tag;
      sb_q.push_back(e);
    end
    @(posedge clock_in);
    m_edge(rst, we, wa, wd);
    #1;
  endtask

  // ---- reference model, instance B ------------------------------------------
  // Never written in RUN, and the zero init means every read is 0.
  int m2_walked = 0;
  bit m2_ready  = 0;
  bit m2_known  = 0;

  task automatic step_b(input bit rst, input bit we, input int wa, input logic [15:0] wd,
                        input int r1, input int r2, input string tag);
    exp_t e;
    reset_b = rst;
    we_b    = we;
    wreg_b  = 5'(wa);
    wdata_b = wd;
    read1_b = 5'(r1);
    read2_b = 5'(r2);
    if (m2_known) begin
      e.inst_b = 1;
      e.rd1    = 32'h0;
      e.rd2    = 32'h0;
      e.rdy    = m2_ready;
      e.tag    = tag;
      sb_q.push_back(e);
    end
    @(posedge clock_in);
    if (rst) begin
      m2_walked = 0;
      m2_ready  = 0;
      m2_known  = 1;
    end else if (!m2_ready) begin
      m2_walked++;
      if (m2_walked == 32) m2_ready = 1;
    end
    #1;
  endtask

  function automatic int rnd_addr();
    return int'($urandom_range(0, 31));
  endfunction

  // ---- stimulus ---------------------------------------------------------------
  initial begin
    int lat;
    int wa;
    int r1;
    int r2;
    bit rst;
    bit we;

    reset = 1'b1; regWrite = 1'b0; writeReg = '0; writeData = '0;
    readReg1 = '0; readReg2 = '0;
    reset_b = 1'b1; we_b = 1'b0; wreg_b = '0; wdata_b = '0;
    read1_b = '0; read2_b = '0;

    // Reset held for three cycles.
    for (int i = 0; i < 3; i++) step(1, 0, 0, 32'h0, rnd_addr(), rnd_addr(), "rst_hold");

    // INIT walk, with a write attempt to reg3 that must be ignored.
    lat = 0;
    for (int i = 0; i < 40; i++) begin
      step(0, 1, 3, 32'hDEADBEEF, rnd_addr(), rnd_addr(), "init");
      lat++;
      if (ready) break;
    end
    check("ready_latency", 32'(lat), 32'd16);

    step(0, 0, 0, 32'h0, 5, 15, "rd5_15");
    step(0, 0, 0, 32'h0, 3, 3, "rd3");

    // Write reg7: the same-cycle read depends on the bypass, the next one does not.
    step(0, 1, 7, 32'h12345678, 7, 7, "wr7_same");
    step(0, 0, 0, 32'h0, 7, 6, "wr7_next");

    // Dropped writes: the zero register and an address beyond DEPTH.
    step(0, 1, 0, 32'hFFFFFFFF, 0, 0, "wr0_same");
    step(0, 0, 0, 32'h0, 0, 1, "wr0_next");
    step(0, 1, 20, 32'hAAAA5555, 20, 7, "wr20_same");
    for (int i = 0; i < 16; i++) step(0, 0, 0, 32'h0, i, 20, "sweep");

    // Reset after the eighth INIT edge restarts the walk.
    step(1, 0, 0, 32'h0, 7, 1, "rst2");
    for (int i = 0; i < 8; i++) step(0, 0, 0, 32'h0, rnd_addr(), rnd_addr(), "part_init");
    step(1, 0, 0, 32'h0, 2, 7, "rst3");
    lat = 0;
    for (int i = 0; i < 40; i++) begin
      step(0, 0, 0, 32'h0, rnd_addr(), rnd_addr(), "reinit");
      lat++;
      if (ready) break;
    end
    check("ready_relatency", 32'(lat), 32'd16);
    step(0, 0, 0, 32'h0, 7, 3, "after_reinit");

    // Randomised traffic with an occasional reset.
    for (int i = 0; i < 300; i++) begin
      rst = ($urandom_range(0, 63) == 0);
      we  = !rst && ($urandom_range(0, 1) == 1);
      wa  = rnd_addr();
      r1  = ($urandom_range(0, 3) == 0) ? wa : rnd_addr();
      r2  = ($urandom_range(0, 3) == 0) ? wa : rnd_addr();
      step(rst, we, wa, $urandom, r1, r2, "rand");
    end
    regWrite = 1'b0;
    reset    = 1'b0;

    // Instance B: ready after 32 INIT edges, and every register reads zero.
    step_b(1, 0, 0, 16'h0, 0, 0, "b_rst");
    step_b(1, 0, 0, 16'h0, 0, 0, "b_rst");
    lat = 0;
    for (int i = 0; i < 80; i++) begin
      step_b(0, 1, rnd_addr(), 16'($urandom), rnd_addr(), rnd_addr(), "b_init");
      lat++;
      if (ready_b) break;
    end
    check("b_ready_latency", 32'(lat), 32'd32);
    for (int i = 0; i < 32; i++) step_b(0, 0, 0, 16'h0, i, 31 - i, "b_sweep");

    @(negedge clock_in);
    #1;
    check("sb_drain", 32'(sb_q.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Upper bound on run time; the stimulus above needs well under 1000 cycles.
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule : tb_regfile_param
